seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared seven_seg decoder across NUM_DIGITS common-anode digits.
//  Holds a double-buffered frame of 4-bit digit codes and accepts new frames via a valid/ready load port.
//  Steps through digits with a programmable dwell time and an all-off blanking gap that suppresses ghosting.
//  Sits between the value-producing datapath and the seven_seg instance plus the board anode drivers.
// PARAMETERS
//  NUM_DIGITS    4      number of multiplexed digits (>=2)
//  DWELL_CYCLES  50000  clk cycles each digit is lit (>=1)
//  BLANK_CYCLES  500    clk cycles all anodes are off before each digit (>=0; 0 = no gap)
// PORTS
//  clk         in   1             single system clock, all logic on rising edge
//  reset_n     in   1             synchronous reset, active-low
//  enable      in   1             1 = scan; 0 = display dark, scan held at start of frame
//  load_valid  in   1             producer presents a new frame on load_data
//  load_ready  out  1             controller can accept a frame (pending buffer empty)
//  load_data   in   4*NUM_DIGITS  digit i code in bits [4i+3:4i]; digit 0 is scanned first
//  dec_a       out  4             code for the seven_seg a input = active[idx]
//  digit_en_n  out  NUM_DIGITS    active-low anode enables, at most one bit low
//  frame_done  out  1             1-cycle pulse on the last SHOW cycle of digit NUM_DIGITS-1
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=BLANK, idx=0, cnt=0, active=0, pending empty;
//   digit_en_n=all 1, dec_a=0, frame_done=0, load_ready=1.
//  Registers: state{BLANK,SHOW}, idx [$clog2(NUM_DIGITS)-1:0], cnt sized for max(DWELL,BLANK),
//   active and pending buffers (4*NUM_DIGITS each), pending_full flag.
//  Outputs decode directly from the registers (no extra stage):
//   digit_en_n[i]=0 iff state==SHOW && idx==i && enable; dec_a=active[idx] in every state.
//  FSM, while enable=1:
//   BLANK: cnt increments; at cnt==BLANK_CYCLES-1: go to SHOW, cnt=0. If BLANK_CYCLES==0, skip BLANK.
//   SHOW: cnt increments; at cnt==DWELL_CYCLES-1: cnt=0, idx wraps NUM_DIGITS-1 -> 0 (else +1),
//    go to BLANK (or directly SHOW if BLANK_CYCLES==0).
//   Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
//  frame_done=1 exactly when state==SHOW && idx==NUM_DIGITS-1 && cnt==DWELL_CYCLES-1 && enable.
//  Load handshake:
//   - load_ready = ~pending_full.
//   - Transfer on the edge where load_valid && load_ready: pending<=load_data, pending_full<=1.
//   - load_data may change freely while load_ready=0; nothing is captured then.
//  Commit (tear-free):
//   - active<=pending and pending_full<=0 on the frame_done edge, so the new frame starts at digit 0.
//   - With enable=0, a full pending buffer commits on the next edge.
//   - Commit and a new transfer never coincide because load_ready=0 whenever pending is full.
//   - load_ready returns to 1 the cycle after commit.
//  enable=0: state<=BLANK, idx<=0, cnt<=0 each edge; all anodes off; loads still accepted.
//   When enable returns to 1, the scan restarts with the BLANK of digit 0.
//  Reset mid-frame or mid-handshake: full reset values, any pending frame is discarded.
//  Codes are passed through unmodified. Glyph and sign interpretation belongs to seven_seg.
// TESTING
//  Params NUM_DIGITS=4, DWELL=4, BLANK=2 for all benches.
//  T1 reset: reset_n=0 for 2 cycles, then 1 with enable=1 ->
//   digit_en_n=4'b1111 for cycles 0-1; 4'b1110 for cycles 2-5; 1111 for 6-7; 4'b1101 for 8-11;
//   frame_done only at cycle 23; pattern repeats every 24 cycles.
//  T2 load: load_data=16'h7F80, load_valid=1 for 1 cycle at cycle 5 ->
//   load_ready=0 from cycle 6; dec_a stays 0 through cycle 23.
//   From cycle 24: load_ready=1, dec_a=0 then 8/F/7 per digit.
//  T3 backpressure: two back-to-back frames A=16'h1234, B=16'h5678 held valid ->
//   A accepted; B stalls until load_ready=1 after A commits; B is displayed one frame after A.
//  T4 enable drop: enable=0 at cycle 9 for 3 cycles ->
//   digit_en_n=1111 during the gap; scan restarts with BLANK at idx 0; a pending frame commits during the gap.
//  T5 reset mid-handshake: pending full, reset_n=0 for 1 cycle ->
//   active=0, load_ready=1, the pending frame is never displayed.
//  T6 BLANK_CYCLES=0 build -> digits lit contiguously; each digit_en_n bit low 4 of every 16 cycles.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: scans a double-buffered frame of 4-bit codes across
// NUM_DIGITS common-anode digits with dwell time and an anti-ghosting blank gap.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              dec_a,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                        : BLANK_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST =
        (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   active_q, active_d;
    logic [FW-1:0]   pending_q, pending_d;
    logic            pending_full_q, pending_full_d;

    logic            transfer;
    logic            commit;

    assign load_ready = ~pending_full_q;
    assign transfer   = load_valid && !pending_full_q;

    assign frame_done = (state_q == ST_SHOW) && (idx_q == IDX_LAST)
                        && (cnt_q == DWELL_LAST) && enable;

    // Swap buffers only at a frame boundary, or at once while dark.
    assign commit = pending_full_q && (frame_done || !enable);

    // Scan sequencer: blank gap, then dwell, per digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0
                                                      : idx_q + IW'(1);
                        state_d = (BLANK_CYCLES == 0) ? ST_SHOW
                                                      : ST_BLANK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Frame buffers: accept into pending, promote to active on commit.
    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (commit) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (transfer) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end
    end

    // Digit select and anode drive straight from the registers.
    always_comb begin
        dec_a      = '0;
        digit_en_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dec_a = active_q[4*i +: 4];
                if (state_q == ST_SHOW && enable) begin
                    digit_en_n[i] = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_BLANK;
            idx_q          <= '0;
            cnt_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed bench for the scan controller,
// plus a second build with no blank gap.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rst0_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  dec_a;
    logic [3:0]  digit_en_n;
    logic        frame_done;

    logic        load_ready0;
    logic [3:0]  dec_a0;
    logic [3:0]  digit_en_n0;
    logic        frame_done0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .dec_a     (dec_a),
        .digit_en_n(digit_en_n),
        .frame_done(frame_done)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(0)
    ) u_dut0 (
        .clk       (clk),
        .reset_n   (rst0_n),
        .enable    (1'b1),
        .load_valid(1'b0),
        .load_ready(load_ready0),
        .load_data (16'h0000),
        .dec_a     (dec_a0),
        .digit_en_n(digit_en_n0),
        .frame_done(frame_done0)
    );

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          p;
        int          d;
        int          ph;
        int          n0;
        int          n3;
        logic [15:0] act;
        logic [15:0] rdy;
        logic [15:0] exp_en;
        logic [15:0] exp_fd;
        logic [15:0] exp_dec;

        n0         = 0;
        n3         = 0;
        reset_n    = 1'b0;
        rst0_n     = 1'b0;
        enable     = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        step();
        step();
        reset_n = 1'b1;
        rst0_n  = 1'b1;

        for (int c = 0; c < 212; c++) begin
            cyc = c;

            if (c < 130)      p = c % 24;
            else if (c < 132) p = 0;
            else if (c < 164) p = (c - 131) % 24;
            else              p = (c - 164) % 24;
            d  = p / 6;
            ph = p % 6;

            if (c < 24)       act = 16'h0000;
            else if (c < 72)  act = 16'h7F80;
            else if (c < 96)  act = 16'h1234;
            else if (c < 130) act = 16'h5678;
            else if (c < 164) act = 16'hABCD;
            else              act = 16'h0000;

            if (c <= 5)        rdy = 16'd1;
            else if (c <= 23)  rdy = 16'd0;
            else if (c <= 48)  rdy = 16'd1;
            else if (c <= 71)  rdy = 16'd0;
            else if (c == 72)  rdy = 16'd1;
            else if (c <= 95)  rdy = 16'd0;
            else if (c <= 120) rdy = 16'd1;
            else if (c <= 129) rdy = 16'd0;
            else if (c <= 161) rdy = 16'd1;
            else if (c <= 163) rdy = 16'd0;
            else               rdy = 16'd1;

            exp_en  = (ph < 2) ? 16'h000F
                               : 16'((~(4'b0001 << d)) & 4'hF);
            exp_fd  = (p == 23) ? 16'd1 : 16'd0;
            exp_dec = (act >> (4 * d)) & 16'h000F;

            chk("digit_en_n", 16'(digit_en_n), exp_en);
            chk("frame_done", 16'(frame_done), exp_fd);
            chk("dec_a",      16'(dec_a),      exp_dec);
            chk("load_ready", 16'(load_ready), rdy);

            if (c >= 1) begin
                chk("t6_onehot", 16'($countones(~digit_en_n0)), 16'd1);
            end
            if (c >= 20 && c <= 35) begin
                if (!digit_en_n0[0]) n0++;
                if (!digit_en_n0[3]) n3++;
            end
            if (c == 36) begin
                chk("t6_low_d0", 16'(n0), 16'd4);
                chk("t6_low_d3", 16'(n3), 16'd4);
            end

            case (c)
                5: begin
                    load_valid = 1'b1;
                    load_data  = 16'h7F80;
                end
                6:   load_valid = 1'b0;
                48: begin
                    load_valid = 1'b1;
                    load_data  = 16'h1234;
                end
                49:  load_data  = 16'h5678;
                73:  load_valid = 1'b0;
                120: begin
                    load_valid = 1'b1;
                    load_data  = 16'hABCD;
                end
                121: load_valid = 1'b0;
                129: enable     = 1'b0;
                131: enable     = 1'b1;
                161: begin
                    load_valid = 1'b1;
                    load_data  = 16'h9999;
                end
                162: load_valid = 1'b0;
                163: reset_n    = 1'b0;
                164: reset_n    = 1'b1;
                default: ;
            endcase

            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
